// File: rtl/l2_request_arbiter.sv
// Shares one L2 request port between the L1 I-cache and D-cache: one transaction in flight, round-robin on ties.
// Optional performance counters are enabled by defining L2_ARB_PERF_CNT_EN.
module l2_request_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
`ifdef L2_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       grant_i_cnt,
  output logic [31:0]       grant_d_cnt,
  output logic [31:0]       conflict_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic                r_is_write;
  logic                r_last_grant;  // 0 = I, 1 = D

  logic w_req_i, w_req_d, w_grant_i, w_grant_d, w_idle;

  assign w_idle    = (r_state == IDLE);
  assign w_req_i   = i_read;
  assign w_req_d   = d_read | d_write;
  // On a tie the side that did not win last time goes first.
  assign w_grant_i = w_idle & w_req_i & (~w_req_d | r_last_grant);
  assign w_grant_d = w_idle & w_req_d & (~w_req_i | ~r_last_grant);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_is_write   <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_state      <= BUSY_I;
            r_addr       <= i_addr;
            r_is_write   <= 1'b0;
            r_last_grant <= 1'b0;
          end else if (w_grant_d) begin
            r_state      <= BUSY_D;
            r_addr       <= d_addr;
            r_wdata      <= d_wdata;
            r_is_write   <= d_write;
            r_last_grant <= 1'b1;
          end
        end
        BUSY_I, BUSY_D: begin
          if (l2_resp) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign l2_read  = ~w_idle & ~r_is_write;
  assign l2_write = ~w_idle &  r_is_write;
  assign l2_addr  = r_addr;
  assign l2_wdata = r_wdata;

  // A response coinciding with reset is swallowed along with the transaction.
  assign i_resp  = rst & l2_resp & (r_state == BUSY_I);
  assign d_resp  = rst & l2_resp & (r_state == BUSY_D);
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

`ifdef L2_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_i_cnt  <= '0;
      grant_d_cnt  <= '0;
      conflict_cnt <= '0;
    end else begin
      if (w_grant_i)                   grant_i_cnt  <= grant_i_cnt + 32'd1;
      if (w_grant_d)                   grant_d_cnt  <= grant_d_cnt + 32'd1;
      if (w_idle & w_req_i & w_req_d)  conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule
